// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit for the E stage of a five-stage MIPS pipeline.
// The result is computed in the start cycle and held in a pending register.
// It is committed to HI/LO after a fixed latency, so the externally visible
// timing matches an iterative unit.
module md_unit #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        pend_valid;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  // operation decode
  logic        is_div;
  logic        is_signed;

  // multiplier datapath
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  // divider datapath
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // selected result
  logic [63:0] res;
  logic        res_valid;

  assign is_div    = md_op[1];
  assign is_signed = ~md_op[0];

  // 64-bit product; sign-extending to 64 bits lets one multiplier serve both forms
  always_comb begin
    mul_a   = {{32{is_signed & src_a[31]}}, src_a};
    mul_b   = {{32{is_signed & src_b[31]}}, src_b};
    product = mul_a * mul_b;
  end

  // Signed divide via magnitudes.
  // The quotient sign is the XOR of the operand signs; the remainder follows the dividend.
  // 0x80000000 / -1 yields 0x80000000 rem 0 with no special case.
  always_comb begin
    dvd_mag  = (is_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    dvs_mag  = (is_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
    dvs_safe = (dvs_mag == '0) ? 32'd1 : dvs_mag;
    q_mag    = dvd_mag / dvs_safe;
    r_mag    = dvd_mag % dvs_safe;
    quot     = (is_signed && (src_a[31] ^ src_b[31])) ? (~q_mag + 32'd1) : q_mag;
    rem      = (is_signed && src_a[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  // Select the pending result; a divide by zero leaves HI/LO untouched at commit
  always_comb begin
    res       = product;
    res_valid = 1'b1;
    if (is_div) begin
      res       = {rem, quot};
      res_valid = (src_b != '0);
    end
  end

  // Sequencer, pending result, and HI/LO register pair
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pend       <= res;
            pend_valid <= res_valid;
            cnt        <= is_div ? DIV_CNT : MUL_CNT;
            state      <= RUN;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            if (pend_valid) begin
              hi_q <= pend[63:32];
              lo_q <= pend[31:0];
            end
            done_q <= 1'b1;
            state  <= IDLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // busy covers the start cycle so the hazard unit can stall immediately
  always_comb begin
    busy = reset_n & (start | (state == RUN));
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline. Owns the HI/LO register pair.
- Drives `busy` to the hazard unit, which stalls any HI/LO-touching instruction (MDFT) in D while `busy` is high.
- Executes mult, multu, div and divu with fixed, parameterised latency.
- Services mthi/mtlo writes; mfhi/mflo read the `hi`/`lo` outputs directly.

Parameters:
- MUL_LAT, 5, number of busy cycles after the start cycle for mult/multu (legal range 1..15).
- DIV_LAT, 10, number of busy cycles after the start cycle for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin an operation; E-stage instruction is mult/multu/div/divu.
- md_op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu; sampled only when start=1.
- src_a  input  32  rs operand, forwarded value.
- src_b  input  32  rt operand, forwarded value.
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- wdata  input  32  mthi/mtlo data.
- busy  output  1  operation pending; goes to the hazard unit as BUSY.
- done  output  1  one-cycle pulse on the cycle HI/LO first show a new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, counter=0, hi=0, lo=0, done=0, pending result registers=0.
  - busy=0 while reset is asserted.
- States: IDLE, RUN.
  - The counter is 4 bits.
  - busy = start | (state==RUN). busy is combinational on start, so the hazard unit stalls a following MDFT instruction in D during the start cycle itself.
- IDLE with start=1 at edge T:
  - The result is computed from src_a/src_b and stored in the 64-bit pending register.
  - counter loads MUL_LAT or DIV_LAT; state becomes RUN.
- RUN:
  - counter decrements each edge.
  - On the edge where counter==1: hi/lo load the pending result (if valid), done goes to 1, state returns to IDLE, counter becomes 0.
  - done is registered and is high for exactly one cycle.
- Timing: busy is high in the start cycle plus LAT further cycles, i.e. LAT+1 cycles total. The new hi/lo values are visible in the first cycle after that, and done=1 in that same cycle.
- Arithmetic:
  - mult: {hi,lo} = signed 32x32 product, 64 bits.
  - multu: {hi,lo} = unsigned 32x32 product, 64 bits.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient in lo, unsigned remainder in hi.
  - Signed overflow case, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (src_b==0, div or divu):
  - The operation runs for the full DIV_LAT and busy behaves normally.
  - hi/lo are not modified; done still pulses.
- mthi/mtlo:
  - Take effect at the next edge: hi_we writes hi, lo_we writes lo, both may be set in the same cycle.
  - Honoured only in IDLE with start=0.
  - Ignored in RUN: the hazard unit already prevents this, and the block does not rely on it.
- start in RUN: ignored. The running operation is not restarted and its operands are not resampled.
- start together with hi_we/lo_we in IDLE: start wins and the write is dropped.
- Reset asserted mid-RUN: the operation is abandoned, everything returns to reset values, and no done pulse follows.
- A Hi/Lo write and a commit never coincide, because writes are ignored in RUN.

Test Plan:
- Unsigned multiply:
  - Stimulus: reset, then start with md_op=01, src_a=0xFFFFFFFF, src_b=2.
  - Required: busy=1 for 6 cycles; in the 7th cycle hi=0x00000001, lo=0xFFFFFFFE, done=1 for one cycle only.
- Signed divide:
  - Stimulus: start with md_op=10, src_a=0xFFFFFFF9 (-7), src_b=2.
  - Required: busy=1 for 11 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed multiply with a held start:
  - Stimulus: md_op=00, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF; start held high for 3 cycles with src_a changed to 5 on cycle 2.
  - Required: a single operation; hi=0, lo=1 after 6 busy cycles.
- Divide by zero:
  - Stimulus: mthi 0x1234, mtlo 0x5678, then divu 10/0.
  - Required: busy for 11 cycles, done pulses, hi=0x1234, lo=0x5678 unchanged.
- Write ignored while busy:
  - Stimulus: lo_we=1, wdata=0xAAAA issued during a mult RUN (3*4).
  - Required: the write is ignored and lo=12 after completion.
  - Follow-up: the same lo_we issued in IDLE gives lo=0xAAAA the next cycle.
- Reset mid-operation:
  - Stimulus: reset_n pulled low asynchronously mid-way through a div.
  - Required: busy, hi, lo and done are 0 immediately; after release the block is IDLE with busy=0.
